// File: rtl/tile_scatter_loader_if.sv
// Handshake, stream and read-port bundle for tile_scatter_loader.
// The master modport is the driving side (controller or bench); slave is the loader.
interface tile_scatter_loader_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TILE_SIZE  = 4,
  parameter int unsigned NUM_TILES  = 16,
  parameter int unsigned DIM_WIDTH  = 8
);
  localparam int unsigned TILE_W = $clog2(NUM_TILES);
  localparam int unsigned ADDR_W = $clog2(TILE_SIZE * TILE_SIZE);

  logic                  start;
  logic [DIM_WIDTH-1:0]  mat_rows;
  logic [DIM_WIDTH-1:0]  mat_cols;
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic [TILE_W-1:0]     rd_tile;
  logic [ADDR_W-1:0]     rd_addr;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic [TILE_W:0]       tile_count;

  modport master (
    output start, mat_rows, mat_cols, in_valid, in_data, rd_tile, rd_addr, rd_en,
    input  in_ready, rd_data, busy, done, err, tile_count
  );

  modport slave (
    input  start, mat_rows, mat_cols, in_valid, in_data, rd_tile, rd_addr, rd_en,
    output in_ready, rd_data, busy, done, err, tile_count
  );
endinterface

// File: rtl/tile_scatter_loader.sv
// Scatters a row-major matrix stream into NUM_TILES banked TILE_SIZE x TILE_SIZE tiles.
// Define ZERO_PAD_EN to accept non-multiple dimensions with zero-cleared edge tiles.
module tile_scatter_loader #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TILE_SIZE  = 4,
  parameter int unsigned NUM_TILES  = 16,
  parameter int unsigned DIM_WIDTH  = 8
) (
  input logic                  clk,
  input logic                  rst,
  tile_scatter_loader_if.slave bus
);
  localparam int unsigned ELEMS  = TILE_SIZE * TILE_SIZE;
  localparam int unsigned TILE_W = $clog2(NUM_TILES);
  localparam int unsigned CNT_W  = TILE_W + 1;
  localparam int unsigned ADDR_W = $clog2(ELEMS);
  localparam int unsigned EXT_W  = DIM_WIDTH + 1;
  localparam int unsigned PROD_W = 2 * EXT_W;
  localparam logic [ADDR_W-1:0] LC_LAST = ADDR_W'(TILE_SIZE - 1);
  localparam logic [ADDR_W-1:0] LR_LAST = ADDR_W'((TILE_SIZE - 1) * TILE_SIZE);
`ifdef ZERO_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
`ifdef ZERO_PAD_EN
    CLEAR = 2'd1,
`endif
    LOAD  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_n;

  logic                  in_ready_q, busy_q, done_q, err_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [CNT_W-1:0]      tile_count_q;

  logic [DIM_WIDTH-1:0]  rows_q, cols_q, row_cnt, col_cnt;
  logic [CNT_W-1:0]      tpr_q, tile_col, row_base;
  logic [ADDR_W-1:0]     lc, lr_base, clr_addr;

  logic [EXT_W-1:0]      tpr, tpc;
  logic [PROD_W-1:0]     tiles;
  logic                  dims_ok, accept, reject, xfer, last_col, last_row;
  logic [CNT_W-1:0]      tile_idx;
  logic [ADDR_W-1:0]     wr_addr;

  logic [DATA_WIDTH-1:0] mem [NUM_TILES][ELEMS];

  // Start admission: tile grid size and divisibility of the requested dimensions
  always_comb begin
    tpr     = (EXT_W'(bus.mat_cols) + EXT_W'(TILE_SIZE - 1)) / EXT_W'(TILE_SIZE);
    tpc     = (EXT_W'(bus.mat_rows) + EXT_W'(TILE_SIZE - 1)) / EXT_W'(TILE_SIZE);
    tiles   = PROD_W'(tpr) * PROD_W'(tpc);
    dims_ok = (bus.mat_rows != '0) && (bus.mat_cols != '0) &&
              (tiles <= PROD_W'(NUM_TILES)) &&
              (PAD_EN ||
               (((EXT_W'(bus.mat_rows) % EXT_W'(TILE_SIZE)) == '0) &&
                ((EXT_W'(bus.mat_cols) % EXT_W'(TILE_SIZE)) == '0)));
  end

  assign xfer     = bus.in_valid && in_ready_q;
  assign last_col = (col_cnt == cols_q - DIM_WIDTH'(1));
  assign last_row = (row_cnt == rows_q - DIM_WIDTH'(1));
  assign tile_idx = row_base + tile_col;
  assign wr_addr  = lr_base + lc;

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    reject  = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          if (dims_ok) begin
            accept = 1'b1;
`ifdef ZERO_PAD_EN
            state_n = CLEAR;
`else
            state_n = LOAD;
`endif
          end else begin
            reject = 1'b1;
          end
        end
      end
`ifdef ZERO_PAD_EN
      CLEAR: if (clr_addr == ADDR_W'(ELEMS - 1)) state_n = LOAD;
`endif
      LOAD: if (xfer && last_col && last_row) state_n = DONE;
      default: state_n = IDLE;
    endcase
  end

  // State register plus status flags registered from the next state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state      <= state_n;
      in_ready_q <= (state_n == LOAD);
      busy_q     <= (state_n != IDLE) && (state_n != DONE);
      done_q     <= (state_n == DONE);
      err_q      <= reject;
    end
  end

  // Scatter counters: local column/row offsets walk inside a tile, tile_col and
  // row_base walk the tile grid so the write path only adds.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rows_q       <= '0;
      cols_q       <= '0;
      tpr_q        <= '0;
      tile_count_q <= '0;
      row_cnt      <= '0;
      col_cnt      <= '0;
      lc           <= '0;
      lr_base      <= '0;
      tile_col     <= '0;
      row_base     <= '0;
      clr_addr     <= '0;
    end else if (accept) begin
      rows_q       <= bus.mat_rows;
      cols_q       <= bus.mat_cols;
      tpr_q        <= CNT_W'(tpr);
      tile_count_q <= CNT_W'(tiles);
      row_cnt      <= '0;
      col_cnt      <= '0;
      lc           <= '0;
      lr_base      <= '0;
      tile_col     <= '0;
      row_base     <= '0;
      clr_addr     <= '0;
    end else begin
`ifdef ZERO_PAD_EN
      if (state == CLEAR) clr_addr <= clr_addr + ADDR_W'(1);
`endif
      if (xfer) begin
        if (last_col) begin
          col_cnt  <= '0;
          lc       <= '0;
          tile_col <= '0;
          row_cnt  <= row_cnt + DIM_WIDTH'(1);
          if (lr_base == LR_LAST) begin
            lr_base  <= '0;
            row_base <= row_base + tpr_q;
          end else begin
            lr_base <= lr_base + ADDR_W'(TILE_SIZE);
          end
        end else begin
          col_cnt <= col_cnt + DIM_WIDTH'(1);
          if (lc == LC_LAST) begin
            lc       <= '0;
            tile_col <= tile_col + CNT_W'(1);
          end else begin
            lc <= lc + ADDR_W'(1);
          end
        end
      end
    end
  end

  // Tile storage is deliberately not reset
  always_ff @(posedge clk) begin
`ifdef ZERO_PAD_EN
    if (state == CLEAR) begin
      for (int t = 0; t < NUM_TILES; t++) mem[TILE_W'(t)][clr_addr] <= '0;
    end
`endif
    if (xfer) mem[TILE_W'(tile_idx)][wr_addr] <= bus.in_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data_q <= '0;
    end else if (bus.rd_en) begin
      rd_data_q <= (32'(bus.rd_tile) < NUM_TILES) ? mem[bus.rd_tile][bus.rd_addr] : '0;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.rd_data    = rd_data_q;
  assign bus.tile_count = tile_count_q;
endmodule

// File: tb/tb_tile_scatter_loader.sv
// Bench for tile_scatter_loader: table of start vectors with random streams checked
// against an array model of the tile banks, plus directed multi-cycle sequences.
`timescale 1ns/1ps
module tb_tile_scatter_loader;
  localparam int DW    = 32;
  localparam int TS    = 4;
  localparam int NT    = 16;
  localparam int DIMW  = 8;
  localparam int ELEMS = TS * TS;
  localparam int TW    = $clog2(NT);
  localparam int AW    = $clog2(ELEMS);
`ifdef ZERO_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  tile_scatter_loader_if #(.DATA_WIDTH(DW), .TILE_SIZE(TS), .NUM_TILES(NT), .DIM_WIDTH(DIMW)) bus ();
  tile_scatter_loader #(.DATA_WIDTH(DW), .TILE_SIZE(TS), .NUM_TILES(NT), .DIM_WIDTH(DIMW))
    dut (.clk(clk), .rst(rst), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] ref_mem [NT][ELEMS];
  bit            known   [NT][ELEMS];
  int            cur_tiles = 0;
  bit            exp_done  = 1'b0;

  typedef struct {
    int rows;
    int cols;
    bit exp_err;
    int exp_tiles;
  } vec_t;
  vec_t vecs [12];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic void loc(input int cols, input int k, output int t, output int a);
    int r, c, tpr;
    r   = k / cols;
    c   = k % cols;
    tpr = (cols + TS - 1) / TS;
    t   = (r / TS) * tpr + c / TS;
    a   = (r % TS) * TS + c % TS;
  endfunction

  function automatic void model_write(input int cols, input int k, input logic [DW-1:0] d);
    int t, a;
    loc(cols, k, t, a);
    ref_mem[t][a] = d;
    known[t][a]   = 1'b1;
  endfunction

  task automatic read_check(input int t, input int a, input logic [DW-1:0] exp, input string tag);
    bus.rd_en   = 1'b1;
    bus.rd_tile = TW'(t);
    bus.rd_addr = AW'(a);
    @(negedge clk);
    bus.rd_en = 1'b0;
    check($sformatf("%s t%0d a%0d", tag, t, a), bus.rd_data, exp);
  endtask

  task automatic verify_all(input string tag);
    for (int t = 0; t < NT; t++)
      for (int a = 0; a < ELEMS; a++)
        if (known[t][a]) read_check(t, a, ref_mem[t][a], tag);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_in_ready"}, bus.in_ready, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_err"}, bus.err, 0);
    check({tag, "_tile_count"}, bus.tile_count, 0);
    check({tag, "_rd_data"}, bus.rd_data, 0);
  endtask

  // Pulse start and check admission; on accept also wait out any clear phase
  task automatic do_start(input int rows, input int cols, input bit exp_err,
                          input int exp_tiles, output bit accepted);
    int n, guard;
    bus.start    = 1'b1;
    bus.mat_rows = DIMW'(rows);
    bus.mat_cols = DIMW'(cols);
    @(negedge clk);
    bus.start = 1'b0;
    check($sformatf("err %0dx%0d", rows, cols), bus.err, exp_err);
    check($sformatf("busy %0dx%0d", rows, cols), bus.busy, !exp_err);
    accepted = !exp_err;
    if (exp_err) begin
      check("done_held_on_reject", bus.done, exp_done);
      check("tile_count_held_on_reject", bus.tile_count, cur_tiles);
      @(negedge clk);
      check("err_one_cycle", bus.err, 0);
    end else begin
      check("done_drop_on_start", bus.done, 0);
      check($sformatf("tile_count %0dx%0d", rows, cols), bus.tile_count, exp_tiles);
      cur_tiles = exp_tiles;
      exp_done  = 1'b0;
      n = 0;
      guard = 0;
      while (!bus.in_ready && guard < 64) begin
        if (bus.busy) n++;
        guard++;
        @(negedge clk);
      end
      check("clear_cycles", n, PAD ? ELEMS : 0);
      if (PAD)
        for (int t = 0; t < NT; t++)
          for (int a = 0; a < ELEMS; a++) begin
            ref_mem[t][a] = '0;
            known[t][a]   = 1'b1;
          end
    end
  endtask

  task automatic stream(input int rows, input int cols, input bit rand_data, input bit rand_valid,
                        input int stop_at, input int start_at, input int rdw_k,
                        output int transfers);
    int k, cycles, t, a;
    bit rdy, v, ready_ok, rdw_pend, st_pend, rdw_done, st_done;
    logic [DW-1:0] d, old;
    k = 0; cycles = 0; ready_ok = 1'b1; transfers = 0;
    rdw_done = 1'b0; st_done = 1'b0; old = '0;
    while (k < rows * cols && k != stop_at) begin
      if (cycles >= 2000) begin
        check("stream_timeout", k, rows * cols);
        break;
      end
      rdy = bus.in_ready;
      if (!rdy) ready_ok = 1'b0;
      v = rand_valid ? ($urandom_range(0, 2) != 0) : 1'b1;
      d = rand_data ? $urandom : DW'(k);
      rdw_pend = 1'b0;
      st_pend  = 1'b0;
      if (k == rdw_k && !rdw_done) begin
        v = 1'b1; rdw_pend = 1'b1; rdw_done = 1'b1;
        loc(cols, k, t, a);
        old = ref_mem[t][a];
        bus.rd_en = 1'b1; bus.rd_tile = TW'(t); bus.rd_addr = AW'(a);
      end
      if (k == start_at && !st_done) begin
        st_pend = 1'b1; st_done = 1'b1;
        bus.start = 1'b1; bus.mat_rows = DIMW'(4); bus.mat_cols = DIMW'(4);
      end
      bus.in_valid = v;
      bus.in_data  = d;
      @(negedge clk);
      cycles++;
      bus.start = 1'b0;
      bus.rd_en = 1'b0;
      if (v && rdy) begin
        model_write(cols, k, d);
        k++;
        transfers++;
      end
      if (rdw_pend) check("read_during_write_old", bus.rd_data, old);
      if (st_pend) check("start_in_load_no_err", bus.err, 0);
    end
    bus.in_valid = 1'b0;
    check("in_ready_high_in_load", ready_ok, 1);
  endtask

  task automatic finish_load();
    check("done_after_load", bus.done, 1);
    check("in_ready_after_load", bus.in_ready, 0);
    check("busy_after_load", bus.busy, 0);
    exp_done = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hDEAD_BEEF;
    repeat (3) @(negedge clk);
    bus.in_valid = 1'b0;
    check("done_held", bus.done, 1);
  endtask

  task automatic run_load(input vec_t v, input bit rand_data, input bit rand_valid);
    bit acc;
    int tr;
    do_start(v.rows, v.cols, v.exp_err, v.exp_tiles, acc);
    if (acc) begin
      stream(v.rows, v.cols, rand_data, rand_valid, -1, -1, -1, tr);
      check($sformatf("transfers %0dx%0d", v.rows, v.cols), tr, v.rows * v.cols);
      finish_load();
      verify_all($sformatf("tile %0dx%0d", v.rows, v.cols));
    end
  endtask

  initial begin
    #900us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int tr;
    vec_t v;
    vecs[0]  = '{8, 8, 1'b0, 4};
    vecs[1]  = '{20, 20, 1'b1, 0};
    vecs[2]  = '{0, 8, 1'b1, 0};
    vecs[3]  = '{8, 0, 1'b1, 0};
    vecs[4]  = '{4, 4, 1'b0, 1};
    vecs[5]  = '{16, 16, 1'b0, 16};
    vecs[6]  = '{16, 20, 1'b1, 0};
    vecs[7]  = '{6, 4, !PAD, 2};
    vecs[8]  = '{12, 8, 1'b0, 6};
    vecs[9]  = '{1, 1, !PAD, 1};
    vecs[10] = '{5, 13, !PAD, 8};
    vecs[11] = '{4, 255, 1'b1, 0};

    bus.start = 1'b0; bus.mat_rows = '0; bus.mat_cols = '0;
    bus.in_valid = 1'b0; bus.in_data = '0;
    bus.rd_en = 1'b0; bus.rd_tile = '0; bus.rd_addr = '0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b1;
    @(negedge clk);

    // 8x8 sequential data, valid held high
    v = '{8, 8, 1'b0, 4};
    do_start(8, 8, 1'b0, 4, acc);
    stream(8, 8, 1'b0, 1'b0, -1, -1, -1, tr);
    check("transfers_8x8", tr, 64);
    finish_load();
    check("tile_count_8x8", bus.tile_count, 4);
    read_check(0, 0, 0, "t1");
    read_check(1, 0, 4, "t1");
    read_check(2, 0, 32, "t1");
    read_check(3, 15, 63, "t1");
    read_check(1, 5, 13, "t1");
    verify_all("t1_all");

    // Same load with ragged valid
    run_load(v, 1'b0, 1'b1);

    for (int i = 0; i < 12; i++) run_load(vecs[i], 1'b1, 1'b1);

`ifdef ZERO_PAD_EN
    do_start(6, 4, 1'b0, 2, acc);
    stream(6, 4, 1'b0, 1'b0, -1, -1, -1, tr);
    finish_load();
    read_check(0, 15, 15, "pad");
    read_check(1, 7, 23, "pad");
    for (int a = 8; a < ELEMS; a++) read_check(1, a, 0, "pad_zero");
`endif

    // Start ignored mid-load, plus a same-cycle read/write at element 30
    do_start(8, 8, 1'b0, 4, acc);
    stream(8, 8, 1'b1, 1'b1, -1, 20, 30, tr);
    check("transfers_start_ignored", tr, 64);
    finish_load();
    check("tile_count_after_ignored_start", bus.tile_count, 4);
    verify_all("t6_all");

    read_check(2, 3, ref_mem[2][3], "hold_src");
    bus.rd_tile = TW'(0);
    bus.rd_addr = AW'(0);
    @(negedge clk);
    check("rd_data_hold", bus.rd_data, ref_mem[2][3]);

    // Reset after 10 transfers, then a fresh 4x4 load
    do_start(8, 8, 1'b0, 4, acc);
    stream(8, 8, 1'b1, 1'b0, 10, -1, -1, tr);
    check("transfers_before_reset", tr, 10);
    rst = 1'b0;
    #1;
    check_outputs_zero("midload_reset");
    for (int t = 0; t < NT; t++)
      for (int a = 0; a < ELEMS; a++) known[t][a] = 1'b0;
    cur_tiles = 0;
    exp_done  = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("idle_after_reset_busy", bus.busy, 0);
    do_start(4, 4, 1'b0, 1, acc);
    stream(4, 4, 1'b0, 1'b0, -1, -1, -1, tr);
    check("transfers_4x4", tr, 16);
    finish_load();
    read_check(0, 15, 15, "after_reset");
    verify_all("after_reset_all");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
